instr_encoder_loader: RTL and testbench

Programs instruction memory from an instruction-level request stream. This is the inverse of the main control decoder. The block accepts an operation class plus register, immediate and target fields over a valid/ready handshake and encodes each request into a 32-bit MIPS word using the opcode map the CPU decodes. It buffers the words in a small FIFO and writes them to sequential instruction-memory addresses. It sits between the test/boot sequencer and the instruction memory write port.

---
 rtl/instr_encoder_loader_if.sv | 31 +++
 rtl/instr_encoder_loader.sv | 146 ++++++++++++++
 tb/tb_instr_encoder_loader.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_loader_if.sv
// Request stream and instruction-memory write bus for instr_encoder_loader.
// The slave modport is the loader's view; master is the sequencer/memory side.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [3:0]        op_sel_i;
    logic [4:0]        rs_i;
    logic [4:0]        rt_i;
    logic [4:0]        rd_i;
    logic [5:0]        funct_i;
    logic [15:0]       imm_i;
    logic [25:0]       target_i;
    logic              mem_we_o;
    logic [ADDR_W+1:0] mem_addr_o;
    logic [31:0]       mem_data_o;
    logic              mem_ready_i;

    modport slave (
        input  req_valid_i, op_sel_i, rs_i, rt_i, rd_i, funct_i, imm_i, target_i,
        input  mem_ready_i,
        output req_ready_o, mem_we_o, mem_addr_o, mem_data_o
    );

    modport master (
        output req_valid_i, op_sel_i, rs_i, rt_i, rd_i, funct_i, imm_i, target_i,
        output mem_ready_i,
        input  req_ready_o, mem_we_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes instruction-level requests into 32-bit MIPS words, buffers them in
// a small FIFO and writes them to sequential instruction-memory addresses.
module instr_encoder_loader #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [ADDR_W+1:0]        base_addr_i,
    input  logic                     end_i,
    instr_encoder_loader_if.slave    bus_if,
    output logic [ADDR_W:0]          count_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] OCC_FULL = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state_q;
    logic [31:0]       fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W:0]    occ_q;
    logic [PTR_W:0]    occ_d;
    logic [ADDR_W+1:0] addr_q;
    logic [ADDR_W:0]   count_q;
    logic              err_q;

    logic [31:0]       enc_word;
    logic              enc_legal;
    logic              accept;
    logic              push;
    logic              pop;

    // Opcode map matching the CPU's main control decoder.
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (bus_if.op_sel_i)
            4'd0:  enc_word = {6'd0,  bus_if.rs_i, bus_if.rt_i, bus_if.rd_i, 5'd0, bus_if.funct_i};
            4'd1:  enc_word = {6'd1,  bus_if.rs_i, 5'd0, bus_if.imm_i};
            4'd2:  enc_word = {6'd2,  bus_if.target_i};
            4'd3:  enc_word = {6'd3,  bus_if.target_i};
            4'd4:  enc_word = {6'd4,  bus_if.rs_i, bus_if.rt_i, bus_if.imm_i};
            4'd5:  enc_word = {6'd5,  bus_if.rs_i, bus_if.rt_i, bus_if.imm_i};
            4'd6:  enc_word = {6'd6,  bus_if.rs_i, bus_if.rt_i, bus_if.imm_i};
            4'd7:  enc_word = {6'd8,  bus_if.rs_i, bus_if.rt_i, bus_if.imm_i};
            4'd8:  enc_word = {6'd11, bus_if.rs_i, bus_if.rt_i, bus_if.imm_i};
            4'd9:  enc_word = {6'd13, bus_if.rs_i, bus_if.rt_i, bus_if.imm_i};
            4'd10: enc_word = {6'd15, 5'd0, bus_if.rt_i, bus_if.imm_i};
            4'd11: enc_word = {6'd35, bus_if.rs_i, bus_if.rt_i, bus_if.imm_i};
            4'd12: enc_word = {6'd43, bus_if.rs_i, bus_if.rt_i, bus_if.imm_i};
            default: enc_legal = 1'b0;
        endcase
    end

    // Ready depends only on registered state, never on req_valid_i.
    assign bus_if.req_ready_o = (state_q == RUN) && (occ_q != OCC_FULL);
    assign accept             = bus_if.req_valid_i && bus_if.req_ready_o;
    assign push               = accept && enc_legal;
    assign bus_if.mem_we_o    = (occ_q != '0);
    assign pop                = bus_if.mem_we_o && bus_if.mem_ready_i;
    assign bus_if.mem_data_o  = fifo_q[rd_ptr_q];
    assign bus_if.mem_addr_o  = addr_q;
    assign count_o            = count_q;
    assign err_o              = err_q;
    assign busy_o             = (state_q == RUN) || (state_q == DRAIN);
    assign done_o             = (state_q == DONE);

    // Next FIFO occupancy; simultaneous push and pop cancel out.
    always_comb begin
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // Encoded-word FIFO storage and pointers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= enc_word;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            occ_q <= occ_d;
        end
    end

    // Load-sequencing FSM with write address, written-word count and error flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (pop) begin
                addr_q <= addr_q + (ADDR_W+2)'(4);
                if (count_q != '1) begin
                    count_q <= count_q + 1'b1;
                end
            end
            if (accept && !enc_legal) begin
                err_q <= 1'b1;
            end
            case (state_q)
                IDLE, DONE: begin
                    // FIFO is always empty here, so start cannot race a pop.
                    if (start_i) begin
                        addr_q  <= base_addr_i & ~((ADDR_W+2)'(3));
                        count_q <= '0;
                        err_q   <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (end_i) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (occ_d == '0) begin
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed self-checking bench for instr_encoder_loader.
module tb_instr_encoder_loader;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              end_r = 1'b0;
    logic [ADDR_W+1:0] base = '0;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              done;
    logic              err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [ADDR_W+1:0] wa [$];
    logic [31:0]       wd [$];

    instr_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder_loader #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .base_addr_i (base),
        .end_i       (end_r),
        .bus_if      (bus),
        .count_o     (count),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    // Record each write that will complete at the coming rising edge.
    always @(negedge clk) begin
        if (!rst && bus.mem_we_o && bus.mem_ready_i) begin
            wa.push_back(bus.mem_addr_o);
            wd.push_back(bus.mem_data_o);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm,
                        input logic [25:0] tgt);
        int k;
        logic seen;
        bus.op_sel_i = op;  bus.rs_i = rs;  bus.rt_i = rt;  bus.rd_i = rd;
        bus.funct_i = fn;   bus.imm_i = imm; bus.target_i = tgt;
        bus.req_valid_i = 1'b1;
        seen = 1'b0;
        k = 0;
        while (!seen && k < 200) begin
            @(negedge clk);
            seen = bus.req_ready_o;
            k++;
        end
        chk("accept", 32'(seen), 32'd1);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
    endtask

    task automatic do_start(input logic [ADDR_W+1:0] b);
        base = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_writes(input int n);
        int k = 0;
        while (wa.size() < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("write_count", 32'(wa.size()), 32'(n));
    endtask

    task automatic finish_load();
        int k = 0;
        end_r = 1'b1;
        @(posedge clk); #1;
        end_r = 1'b0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("done", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        bus.req_valid_i = 1'b0; bus.op_sel_i = '0; bus.rs_i = '0; bus.rt_i = '0;
        bus.rd_i = '0; bus.funct_i = '0; bus.imm_i = '0; bus.target_i = '0;
        bus.mem_ready_i = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_we", 32'(bus.mem_we_o), 32'd0);
        chk("rst_ready", 32'(bus.req_ready_o), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr_o), 32'd0);
        chk("rst_data", bus.mem_data_o, 32'd0);
        @(posedge clk); #1;

        // 1: single addi
        do_start(10'h040);
        @(negedge clk);
        chk("busy_run", 32'(busy), 32'd1);
        @(posedge clk); #1;
        send(4'd7, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0005, 26'd0);
        wait_writes(1);
        @(negedge clk);
        chk("t1_addr", 32'(wa[0]), 32'h040);
        chk("t1_data", wd[0], 32'h20080005);
        chk("t1_count", 32'(count), 32'd1);
        @(posedge clk); #1;

        // 2: R-type, jal, lw
        send(4'd0, 5'd8, 5'd9, 5'd10, 6'h20, 16'h0, 26'd0);
        send(4'd3, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0000010);
        send(4'd11, 5'd8, 5'd9, 5'd0, 6'd0, 16'h0004, 26'd0);
        wait_writes(4);
        chk("t2_a1", 32'(wa[1]), 32'h044);
        chk("t2_d1", wd[1], 32'h01095020);
        chk("t2_a2", 32'(wa[2]), 32'h048);
        chk("t2_d2", wd[2], 32'h0C000010);
        chk("t2_a3", 32'(wa[3]), 32'h04C);
        chk("t2_d3", wd[3], 32'h8D090004);
        @(posedge clk); #1;

        // 3: back-pressure, FIFO fills after 4 accepts
        bus.mem_ready_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send(4'd7, 5'd0, 5'd8, 5'd0, 6'd0, 16'(i), 26'd0);
        end
        bus.op_sel_i = 4'd7; bus.imm_i = 16'd5; bus.req_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_ready_low", 32'(bus.req_ready_o), 32'd0);
            chk("t3_we_hold", 32'(bus.mem_we_o), 32'd1);
            chk("t3_addr_hold", 32'(bus.mem_addr_o), 32'h050);
            chk("t3_data_hold", bus.mem_data_o, 32'h20080001);
        end
        @(posedge clk); #1;
        bus.mem_ready_i = 1'b1;
        send(4'd7, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5, 26'd0);
        wait_writes(9);
        repeat (4) @(negedge clk);
        chk("t3_no_dup", 32'(wa.size()), 32'd9);
        for (int i = 0; i < 5; i++) begin
            chk("t3_addr", 32'(wa[4+i]), 32'h050 + 32'(4*i));
            chk("t3_data", wd[4+i], 32'h20080001 + 32'(i));
        end
        chk("t3_count", 32'(count), 32'd9);
        @(posedge clk); #1;
        finish_load();

        // 4: illegal op between two legal requests
        do_start(10'h100);
        send(4'd7, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0006, 26'd0);
        send(4'd14, 5'd1, 5'd2, 5'd3, 6'd0, 16'h1111, 26'd0);
        @(negedge clk);
        chk("t4_err", 32'(err), 32'd1);
        @(posedge clk); #1;
        send(4'd7, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0007, 26'd0);
        wait_writes(11);
        repeat (5) @(negedge clk);
        chk("t4_only2", 32'(wa.size()), 32'd11);
        chk("t4_count", 32'(count), 32'd2);
        chk("t4_a0", 32'(wa[9]), 32'h100);
        chk("t4_d0", wd[9], 32'h20080006);
        chk("t4_a1", 32'(wa[10]), 32'h104);
        chk("t4_d1", wd[10], 32'h20080007);
        @(posedge clk); #1;
        finish_load();
        chk("t4_err_sticky", 32'(err), 32'd1);

        // 5: address wrap and forced-zero fields
        do_start(10'h3FE);
        @(negedge clk);
        chk("t5_err_clr", 32'(err), 32'd0);
        chk("t5_base_align", 32'(bus.mem_addr_o), 32'h3FC);
        @(posedge clk); #1;
        send(4'd1, 5'd2, 5'd7, 5'd0, 6'd0, 16'hFFFE, 26'd0);
        send(4'd10, 5'd3, 5'd4, 5'd0, 6'd0, 16'h1234, 26'd0);
        wait_writes(13);
        chk("t5_a0", 32'(wa[11]), 32'h3FC);
        chk("t5_d0", wd[11], 32'h0440FFFE);
        chk("t5_a1", 32'(wa[12]), 32'h000);
        chk("t5_d1", wd[12], 32'h3C041234);
        @(posedge clk); #1;

        // 6: reset with three words buffered
        bus.mem_ready_i = 1'b0;
        send(4'd2, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0000123);
        send(4'd2, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0000124);
        send(4'd2, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0000125);
        @(negedge clk);
        chk("t6_we_pre", 32'(bus.mem_we_o), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_we", 32'(bus.mem_we_o), 32'd0);
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_ready", 32'(bus.req_ready_o), 32'd0);
        @(posedge clk); #1;
        bus.mem_ready_i = 1'b1;
        do_start(10'h200);
        repeat (6) @(negedge clk);
        chk("t6_discarded", 32'(wa.size()), 32'd13);
        @(posedge clk); #1;
        send(4'd12, 5'd29, 5'd31, 5'd0, 6'd0, 16'h0008, 26'd0);
        wait_writes(14);
        chk("t6_a", 32'(wa[13]), 32'h200);
        chk("t6_d", wd[13], 32'hAFBF0008);
        @(posedge clk); #1;
        finish_load();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
